// File: rtl/pair_serializer_if.sv
// Valid/ready stream bundle with end-of-line mark.
// Shared by the pair input and the sample output.
interface pair_serializer_if #(
   parameter int Width = 16
) ();
   logic             valid;
   logic             ready;
   logic             eol;
   logic [Width-1:0] data;

   modport master (
      output valid,
      output eol,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  eol,
      input  data,
      output ready
   );
endinterface

// File: rtl/pair_serializer.sv
// Splits {odd,even} pairs into an even-then-odd sample stream.
// Also checks each line's pair count against side_size_i.
module pair_serializer #(
   parameter int DataWidth       = 16,
   parameter int MaximumSideSize = 1024,
   localparam int SW = $clog2(MaximumSideSize)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [SW-1:0]      side_size_i,
   pair_serializer_if.slave   din,
   pair_serializer_if.master  dout,
   output logic               len_err_o
);

   typedef enum logic [1:0] {
      EMPTY,
      EVEN,
      ODD
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [DataWidth-1:0] odd_q;
   logic [DataWidth-1:0] dout_q;
   logic                 eol_q;
   logic                 dout_eol_q;

   logic [SW-1:0] cnt;
   logic [SW-1:0] exp_q;
   logic [SW-1:0] exp_cur;
   logic [SW-1:0] cnt_inc;
   logic          hit;
   logic          err_q;

   logic acc;
   logic adv;

   // The odd slot can be refilled in the same cycle it drains.
   assign din.ready  = (state == EMPTY) |
                       ((state == ODD) & dout.ready);
   assign acc        = din.valid & din.ready;
   assign adv        = (state == EVEN) & dout.ready;

   assign dout.valid = (state != EMPTY);
   assign dout.data  = dout_q;
   assign dout.eol   = dout_eol_q;
   assign len_err_o  = err_q;

   // The expected length is latched only on the first pair of a line.
   assign exp_cur = (cnt == '0) ?
                    {1'b0, side_size_i[SW-1:1]} : exp_q;
   assign cnt_inc = cnt + {{(SW-1){1'b0}}, 1'b1};
   assign hit     = (cnt_inc == exp_cur);

   // Next-state selection for the output slot.
   always_comb begin
      state_nxt = state;
      unique case (state)
         EMPTY: begin
            if (acc) state_nxt = EVEN;
         end
         EVEN: begin
            if (dout.ready) state_nxt = ODD;
         end
         ODD: begin
            if (dout.ready)
               state_nxt = acc ? EVEN : EMPTY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= EMPTY;
      else       state <= state_nxt;
   end

   // Pair holding and registered output sample.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         odd_q      <= '0;
         eol_q      <= 1'b0;
         dout_q     <= '0;
         dout_eol_q <= 1'b0;
      end else if (acc) begin
         dout_q     <= din.data[DataWidth-1:0];
         dout_eol_q <= 1'b0;
         odd_q      <= din.data[2*DataWidth-1:DataWidth];
         eol_q      <= din.eol;
      end else if (adv) begin
         dout_q     <= odd_q;
         dout_eol_q <= eol_q;
      end
   end

   // Line length tracking; an early eol or a missing eol is sticky.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt   <= '0;
         exp_q <= '0;
         err_q <= 1'b0;
      end else if (acc) begin
         if (cnt == '0) exp_q <= exp_cur;
         if (din.eol | hit) cnt <= '0;
         else               cnt <= cnt_inc;
         if (din.eol != hit) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pair_serializer.sv
// Self-checking bench for pair_serializer.
// Queue-based sample model plus a line-length model.
module tb_pair_serializer;

   localparam int DW = 16;
   localparam int SW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [SW-1:0] side = 10'd8;
   logic          len_err;

   pair_serializer_if #(.Width(2*DW)) din ();
   pair_serializer_if #(.Width(DW))   dout ();

   pair_serializer #(
      .DataWidth(DW),
      .MaximumSideSize(1024)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .side_size_i(side),
      .din(din),
      .dout(dout),
      .len_err_o(len_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic          e;
   } samp_t;

   int    vectors     = 0;
   int    miscompares = 0;
   samp_t q[$];
   samp_t s;
   int    outstanding = 0;
   int    line_cnt    = 0;
   int    line_exp    = 0;
   logic  err_m       = 1'b0;
   int    rmode       = 0;

   task automatic chk(string tag, logic [31:0] obs,
                      logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(logic [DW-1:0] e, logic [DW-1:0] o,
                       logic l);
      bit a;
      a = 1'b0;
      din.valid = 1'b1;
      din.data  = {o, e};
      din.eol   = l;
      for (int i = 0; i < 1000 && !a; i++) begin
         @(negedge clk);
         a = din.ready;
         @(posedge clk);
         #1;
      end
      chk("send_timeout", 32'(a), 32'd1);
      din.valid = 1'b0;
      din.data  = 32'($urandom);
      din.eol   = 1'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 2000 && outstanding != 0; i++)
         cyc(1);
      chk("drain", 32'(outstanding), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic line(int pairs, int eol_at, int base);
      for (int k = 0; k < pairs; k++)
         send(DW'(base + 2*k), DW'(base + 2*k + 1),
              k == eol_at);
   endtask

   // Reference model and per-cycle output checks.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         outstanding = 0;
         line_cnt    = 0;
         line_exp    = 0;
         err_m       = 1'b0;
      end else begin
         chk("dout_valid", 32'(dout.valid),
             32'(outstanding > 0));
         chk("din_ready", 32'(din.ready),
             32'((outstanding == 0) ||
                 (outstanding == 1 && dout.ready)));
         chk("len_err", 32'(len_err), 32'(err_m));
         if (dout.valid) begin
            chk("sample_avail", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
               chk("dout_data", 32'(dout.data), 32'(q[0].d));
               chk("dout_eol", 32'(dout.eol), 32'(q[0].e));
            end
            if (dout.ready) begin
               if (q.size() > 0) s = q.pop_front();
               outstanding--;
            end
         end
         if (din.valid && din.ready) begin
            q.push_back('{d: din.data[DW-1:0], e: 1'b0});
            q.push_back('{d: din.data[2*DW-1:DW],
                          e: din.eol});
            outstanding += 2;
            line_cnt++;
            if (line_cnt == 1) line_exp = int'(side) / 2;
            if (din.eol) begin
               if (line_cnt != line_exp) err_m = 1'b1;
               line_cnt = 0;
            end else if (line_cnt == line_exp) begin
               err_m    = 1'b1;
               line_cnt = 0;
            end
         end
      end
   end

   // Downstream ready pattern.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       dout.ready = 1'b1;
            1:       dout.ready = ~dout.ready;
            default: dout.ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      din.valid  = 1'b0;
      din.data   = '0;
      din.eol    = 1'b0;
      dout.ready = 1'b1;
      rmode      = 0;
      side       = 10'd8;
      rst        = 1'b1;
      cyc(3);
      rst = 1'b0;

      @(negedge clk);
      chk("rst_dout_valid", 32'(dout.valid), 32'd0);
      chk("rst_din_ready", 32'(din.ready), 32'd1);
      chk("rst_len_err", 32'(len_err), 32'd0);
      chk("rst_dout_data", 32'(dout.data), 32'd0);
      chk("rst_dout_eol", 32'(dout.eol), 32'd0);
      cyc(1);

      line(4, 3, 0);
      drain();

      rmode = 1;
      line(4, 3, 0);
      drain();
      rmode = 0;
      cyc(2);

      send(16'd0, 16'd1, 1'b0);
      send(16'd2, 16'd3, 1'b0);
      chk("short_pre_err", 32'(len_err), 32'd0);
      send(16'd4, 16'd5, 1'b1);
      chk("short_err", 32'(len_err), 32'd1);
      line(4, 3, 100);
      drain();
      chk("short_sticky", 32'(len_err), 32'd1);

      do_reset();
      chk("rst_clears_err", 32'(len_err), 32'd0);
      line(4, -1, 200);
      drain();
      chk("overrun_err", 32'(len_err), 32'd1);
      do_reset();

      send(16'd0, 16'd1, 1'b0);
      send(16'd2, 16'd3, 1'b0);
      cyc(1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("mid_rst_valid", 32'(dout.valid), 32'd0);
      line(4, 3, 300);
      drain();
      chk("mid_rst_no_err", 32'(len_err), 32'd0);

      side  = 10'd16;
      rmode = 2;
      for (int ln = 0; ln < 100; ln++) begin
         for (int p = 0; p < 8; p++) begin
            cyc($urandom_range(0, 2));
            send(DW'($urandom), DW'($urandom), p == 7);
         end
      end
      drain();
      chk("random_no_err", 32'(len_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
